// File: rtl/key_debouncer_if.sv
// Key conditioner bus: raw key levels in, debounced level and edge pulses out.
// The master drives the raw keys; the slave (the debouncer) drives the rest.
interface key_debouncer_if #(
  parameter int unsigned KEYS_W = 4
);
  logic [KEYS_W-1:0] keys_i;
  logic [KEYS_W-1:0] keys_o;
  logic [KEYS_W-1:0] keys_pressed_o;
  logic [KEYS_W-1:0] keys_released_o;

  modport master (
    output keys_i,
    input  keys_o,
    input  keys_pressed_o,
    input  keys_released_o
  );

  modport slave (
    input  keys_i,
    output keys_o,
    output keys_pressed_o,
    output keys_released_o
  );
endinterface

// File: rtl/key_debouncer.sv
// Per-key two-flop synchroniser, stability-counter debouncer and registered
// press/release pulse generator for active-high push-button levels.
module key_debouncer #(
  parameter int unsigned KEYS_W          = 4,
  parameter int unsigned DEBOUNCE_CYCLES = 500000
) (
  input  logic           clk_i,
  input  logic           rst_i,
  key_debouncer_if.slave kb
);
  localparam int unsigned      CNT_W    = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  typedef enum logic {
    ST_STABLE,
    ST_PENDING
  } state_e;

  logic [KEYS_W-1:0] sync1_q;
  logic [KEYS_W-1:0] sync2_q;
  logic [KEYS_W-1:0] level_q,   level_d;
  logic [KEYS_W-1:0] pressed_q, pressed_d;
  logic [KEYS_W-1:0] release_q, release_d;
  state_e            state_q [KEYS_W];
  state_e            state_d [KEYS_W];
  logic [CNT_W-1:0]  cnt_q   [KEYS_W];
  logic [CNT_W-1:0]  cnt_d   [KEYS_W];

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      sync1_q   <= '0;
      sync2_q   <= '0;
      level_q   <= '0;
      pressed_q <= '0;
      release_q <= '0;
      for (int unsigned k = 0; k < KEYS_W; k++) begin
        state_q[k] <= ST_STABLE;
        cnt_q[k]   <= '0;
      end
    end else begin
      sync1_q   <= kb.keys_i;
      sync2_q   <= sync1_q;
      level_q   <= level_d;
      pressed_q <= pressed_d;
      release_q <= release_d;
      for (int unsigned k = 0; k < KEYS_W; k++) begin
        state_q[k] <= state_d[k];
        cnt_q[k]   <= cnt_d[k];
      end
    end
  end

  always_comb begin
    level_d   = level_q;
    pressed_d = '0;
    release_d = '0;
    for (int unsigned k = 0; k < KEYS_W; k++) begin
      state_d[k] = state_q[k];
      cnt_d[k]   = cnt_q[k];
      unique case (state_q[k])
        ST_STABLE: begin
          if (sync2_q[k] != level_q[k]) begin
            state_d[k] = ST_PENDING;
            cnt_d[k]   = CNT_ONE;
          end
        end
        ST_PENDING: begin
          if (sync2_q[k] == level_q[k]) begin
            state_d[k] = ST_STABLE;
            cnt_d[k]   = '0;
          end else if (cnt_q[k] == CNT_LAST) begin
            // Accept: level and its edge pulse are registered on the same edge.
            state_d[k]   = ST_STABLE;
            cnt_d[k]     = '0;
            level_d[k]   = sync2_q[k];
            pressed_d[k] = sync2_q[k];
            release_d[k] = ~sync2_q[k];
          end else begin
            cnt_d[k] = cnt_q[k] + CNT_ONE;
          end
        end
        default: begin
          state_d[k] = ST_STABLE;
          cnt_d[k]   = '0;
        end
      endcase
    end
  end

  assign kb.keys_o          = level_q;
  assign kb.keys_pressed_o  = pressed_q;
  assign kb.keys_released_o = release_q;
endmodule

// File: tb/tb_key_debouncer.sv
// Directed bench for key_debouncer with KEYS_W=4, DEBOUNCE_CYCLES=4: a per-edge
// vector table plus hand-written reset sequences.
module tb_key_debouncer;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_checks = 0;
  int   n_errors = 0;

  key_debouncer_if #(.KEYS_W(4)) bus ();

  key_debouncer #(
    .KEYS_W          (4),
    .DEBOUNCE_CYCLES (4)
  ) dut (
    .clk_i (clk),
    .rst_i (rst),
    .kb    (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] keys;
    logic [3:0] lvl;
    logic [3:0] prs;
    logic [3:0] rel;
  } vec_t;

  vec_t tbl[$];

  task automatic add(input logic [3:0] k, input logic [3:0] l,
                     input logic [3:0] p, input logic [3:0] r, input int n);
    vec_t v;
    v.keys = k; v.lvl = l; v.prs = p; v.rel = r;
    for (int i = 0; i < n; i++) tbl.push_back(v);
  endtask

  task automatic chk(input string name, input logic [3:0] act, input logic [3:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk_all(input string tag, input logic [3:0] l,
                         input logic [3:0] p, input logic [3:0] r);
    chk({tag, " keys_o"},          bus.keys_o,          l);
    chk({tag, " keys_pressed_o"},  bus.keys_pressed_o,  p);
    chk({tag, " keys_released_o"}, bus.keys_released_o, r);
  endtask

  task automatic edge_wait();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int presses;

    // Each vector: keys applied, sampled by the next edge, outputs checked after it.
    add(4'h1, 4'h0, 4'h0, 4'h0, 5);   // clean press key0
    add(4'h1, 4'h1, 4'h1, 4'h0, 1);
    add(4'h1, 4'h1, 4'h0, 4'h0, 1);
    add(4'h3, 4'h1, 4'h0, 4'h0, 2);   // key1 bounce, 2-cycle phases
    add(4'h1, 4'h1, 4'h0, 4'h0, 2);
    add(4'h3, 4'h1, 4'h0, 4'h0, 2);
    add(4'h1, 4'h1, 4'h0, 4'h0, 4);
    add(4'h5, 4'h1, 4'h0, 4'h0, 3);   // key2 high 3, low 1, then held
    add(4'h1, 4'h1, 4'h0, 4'h0, 1);
    add(4'h5, 4'h1, 4'h0, 4'h0, 5);
    add(4'h5, 4'h5, 4'h4, 4'h0, 1);
    add(4'h5, 4'h5, 4'h0, 4'h0, 1);
    add(4'hD, 4'h5, 4'h0, 4'h0, 5);   // press key3
    add(4'hD, 4'hD, 4'h8, 4'h0, 1);
    add(4'hD, 4'hD, 4'h0, 4'h0, 1);
    add(4'h4, 4'hD, 4'h0, 4'h0, 5);   // release keys 0 and 3 together
    add(4'h4, 4'h4, 4'h0, 4'h9, 1);
    add(4'h4, 4'h4, 4'h0, 4'h0, 1);

    bus.keys_i = 4'h0;
    repeat (3) begin
      edge_wait();
      chk_all("por", 4'h0, 4'h0, 4'h0);
    end
    rst = 1'b0;

    foreach (tbl[i]) begin
      bus.keys_i = tbl[i].keys;
      edge_wait();
      chk_all($sformatf("vec%0d", i), tbl[i].lvl, tbl[i].prs, tbl[i].rel);
    end

    // Async reset while keys_o is nonzero, all keys held through reset.
    #3;
    bus.keys_i = 4'hF;
    rst = 1'b1;
    #1;
    chk_all("async_rst", 4'h0, 4'h0, 4'h0);
    repeat (2) begin
      edge_wait();
      chk_all("in_rst", 4'h0, 4'h0, 4'h0);
    end
    rst = 1'b0;
    // First edge after release loads s1; acceptance lands D+1 edges later.
    for (int e = 1; e <= 7; e++) begin
      edge_wait();
      chk_all($sformatf("held_rst e%0d", e), (e >= 6) ? 4'hF : 4'h0,
              (e == 6) ? 4'hF : 4'h0, 4'h0);
    end

    bus.keys_i = 4'h0;
    for (int e = 1; e <= 7; e++) begin
      edge_wait();
      chk_all($sformatf("rel_all e%0d", e), (e >= 6) ? 4'h0 : 4'hF,
              4'h0, (e == 6) ? 4'hF : 4'h0);
    end

    // Reset in the middle of a pending press on key1.
    bus.keys_i = 4'h2;
    for (int e = 1; e <= 3; e++) begin
      edge_wait();
      chk_all($sformatf("pend e%0d", e), 4'h0, 4'h0, 4'h0);
    end
    rst = 1'b1;
    edge_wait();
    chk_all("pend_rst", 4'h0, 4'h0, 4'h0);
    rst = 1'b0;
    presses = 0;
    for (int e = 1; e <= 10; e++) begin
      edge_wait();
      if (bus.keys_pressed_o[1]) presses++;
      chk_all($sformatf("post_rst e%0d", e), (e >= 6) ? 4'h2 : 4'h0,
              (e == 6) ? 4'h2 : 4'h0, 4'h0);
    end
    n_checks++;
    if (presses != 1) begin
      n_errors++;
      $display("FAIL press_count: got %0d expected 1", presses);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
